// File: rtl/raybox_input_pkg.sv
// Shared types and constants for the raybox pushbutton front end:
// preset FSM states, button indices and the default debounce width.
package raybox_input_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_LOAD  = 2'd2,
        S_HOLD  = 2'd3
    } sched_state_t;

    // Button indices: K1 is the bottom button, K4 the top one.
    localparam int K1 = 0;
    localparam int K2 = 1;
    localparam int K3 = 2;
    localparam int K4 = 3;

    localparam int NUM_KEYS        = 4;
    localparam int DEFAULT_DB_BITS = 18;

    // Advance a preset index, wrapping after the last of num presets.
    function automatic logic [1:0] next_preset(input logic [1:0] sel, input int num);
        logic [1:0] result;
        if (int'(sel) >= num - 1) begin
            result = 2'd0;
        end else begin
            result = sel + 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/raybox_debounce.sv
// One-bit pushbutton conditioner: 2-flop synchroniser followed by a
// saturating-match debounce counter. Output is the stable (active-low) level.
module raybox_debounce
    import raybox_input_pkg::*;
#(
    parameter int DB_BITS = DEFAULT_DB_BITS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_n,
    output logic stable_n
);

    // The counter tops out one short of all-ones because the update edge
    // itself is the final differing cycle.
    localparam logic [DB_BITS-1:0] CNT_LAST = {{(DB_BITS-1){1'b1}}, 1'b0};
    localparam logic [DB_BITS-1:0] CNT_ONE  = DB_BITS'(1);

    logic               sync1_reg;
    logic               sync2_reg;
    logic               stable_reg;
    logic [DB_BITS-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            stable_reg <= 1'b1;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= in_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign stable_n = stable_reg;

endmodule

// File: rtl/raybox_input_sched.sv
// Pushbutton front end for the raybox core: debounces K1..K4, registers
// movement/debug commands once per frame and sequences preset-load strobes.
module raybox_input_sched
    import raybox_input_pkg::*;
#(
    parameter int DB_BITS          = DEFAULT_DB_BITS,
    parameter int NUM_PRESETS      = 4,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] k_n,
    input  logic       vsync_in,
    output logic       frame_tick,
    output logic       moveL,
    output logic       moveR,
    output logic       moveF,
    output logic       moveB,
    output logic       debugA,
    output logic       debugB,
    output logic       debugC,
    output logic       debugD,
    output logic       write_new_position,
    output logic [1:0] preset_sel
);

    localparam logic VS_IDLE = VSYNC_ACTIVE_LOW;

    logic [3:0]   stable_n;
    logic [3:0]   pressed;

    logic         vs_sync1_reg;
    logic         vs_sync2_reg;
    logic         vs_active;
    logic         vs_active_prev_reg;
    logic         tick_reg;

    logic         all4;
    logic         dbg1;
    logic         dbg2;
    logic         any_pressed;
    logic         move_block;
    logic [3:0]   dbg_level;

    logic [3:0]   move_reg;
    logic [3:0]   dbg_prev_reg;
    logic [3:0]   dbg_pulse_reg;

    sched_state_t state_reg;
    sched_state_t state_next;
    logic         load_strobe;
    logic [1:0]   sel_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            raybox_debounce #(
                .DB_BITS (DB_BITS)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_n     (k_n[gi]),
                .stable_n (stable_n[gi])
            );
        end
    endgenerate

    assign pressed = ~stable_n;

    // Frame tick: one registered pulse per inactive->active vsync transition.
    assign vs_active = vs_sync2_reg ^ VS_IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_sync1_reg       <= VS_IDLE;
            vs_sync2_reg       <= VS_IDLE;
            vs_active_prev_reg <= 1'b0;
            tick_reg           <= 1'b0;
        end else begin
            vs_sync1_reg       <= vsync_in;
            vs_sync2_reg       <= vs_sync1_reg;
            vs_active_prev_reg <= vs_active;
            tick_reg           <= vs_active & ~vs_active_prev_reg;
        end
    end

    assign all4        = &pressed;
    assign any_pressed = |pressed;
    assign dbg1        = pressed[K2] & pressed[K3] & ~all4;
    assign dbg2        = pressed[K1] & pressed[K4] & ~all4;
    assign move_block  = dbg1 | dbg2 | all4 | (state_reg != S_IDLE);

    // Debug levels in output order {D, C, B, A}.
    assign dbg_level[0] = dbg1 & pressed[K4];
    assign dbg_level[1] = dbg1 & pressed[K1];
    assign dbg_level[2] = dbg2 & pressed[K2];
    assign dbg_level[3] = dbg2 & pressed[K3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move_reg      <= '0;
            dbg_prev_reg  <= '0;
            dbg_pulse_reg <= '0;
        end else begin
            dbg_pulse_reg <= '0;
            if (tick_reg) begin
                move_reg      <= move_block ? 4'b0000 : pressed;
                dbg_prev_reg  <= dbg_level;
                dbg_pulse_reg <= dbg_level & ~dbg_prev_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            sel_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_LOAD) begin
                sel_reg <= next_preset(sel_reg, NUM_PRESETS);
            end
        end
    end

    // The strobe is decoded from state so an async reset drops it at once.
    always_comb begin
        state_next  = state_reg;
        load_strobe = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (tick_reg && all4) begin
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (tick_reg) begin
                    state_next = all4 ? S_LOAD : S_IDLE;
                end
            end
            S_LOAD: begin
                load_strobe = 1'b1;
                state_next  = S_HOLD;
            end
            S_HOLD: begin
                if (tick_reg && !any_pressed) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign frame_tick         = tick_reg;
    assign moveB              = move_reg[K1];
    assign moveR              = move_reg[K2];
    assign moveL              = move_reg[K3];
    assign moveF              = move_reg[K4];
    assign debugA             = dbg_pulse_reg[0];
    assign debugB             = dbg_pulse_reg[1];
    assign debugC             = dbg_pulse_reg[2];
    assign debugD             = dbg_pulse_reg[3];
    assign write_new_position = load_strobe;
    assign preset_sel         = sel_reg;

endmodule

// File: tb/tb_raybox_input_sched.sv
// Randomised frame-level bench for raybox_input_sched: stimulus pushes the
// expected per-frame response, a monitor pops it on every frame_tick.
module tb_raybox_input_sched;

    localparam int FRAME  = 200;
    localparam int VS_LEN = 10;
    localparam int NPRE   = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] k_n = 4'hF;
    logic       vsync_in = 1'b1;
    logic       frame_tick;
    logic       moveL, moveR, moveF, moveB;
    logic       debugA, debugB, debugC, debugD;
    logic       write_new_position;
    logic [1:0] preset_sel;

    raybox_input_sched #(
        .DB_BITS          (4),
        .NUM_PRESETS      (NPRE),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .k_n                (k_n),
        .vsync_in           (vsync_in),
        .frame_tick         (frame_tick),
        .moveL              (moveL),
        .moveR              (moveR),
        .moveF              (moveF),
        .moveB              (moveB),
        .debugA             (debugA),
        .debugB             (debugB),
        .debugC             (debugC),
        .debugD             (debugD),
        .write_new_position (write_new_position),
        .preset_sel         (preset_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         tick_cyc;
        logic [3:0] moves;   // {F, L, R, B}
        logic [3:0] dbg;     // {D, C, B, A}
        logic       wnp;
        logic [1:0] sel;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_en = 1'b0;

    // Reference model state, one step per frame.
    int         m_phase = 0;   // 0 idle, 1 armed, 2 holding after a load
    logic [3:0] m_prev_lvl = 4'h0;
    logic [1:0] m_sel = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_tick(input logic [3:0] p, input int tcyc);
        exp_t       e;
        bit         all4, d1, d2;
        logic [3:0] lvl;
        all4 = (p == 4'hF);
        d1   = p[1] && p[2] && !all4;
        d2   = p[0] && p[3] && !all4;
        e.tick_cyc = tcyc;
        e.moves    = (d1 || d2 || all4 || m_phase != 0) ? 4'h0 : p;
        lvl        = {d2 & p[2], d2 & p[1], d1 & p[0], d1 & p[3]};
        e.dbg      = lvl & ~m_prev_lvl;
        m_prev_lvl = lvl;
        e.wnp      = 1'b0;
        e.sel      = m_sel;
        case (m_phase)
            0: if (all4) m_phase = 1;
            1: begin
                if (all4) begin
                    e.wnp   = 1'b1;
                    m_sel   = 2'((int'(m_sel) + 1) % NPRE);
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: if (p == 4'h0) m_phase = 0;
        endcase
        sb_q.push_back(e);
    endtask

    // One 200-cycle frame; the new button pattern lands early enough to be
    // debounced well before the next vsync, optionally after a short glitch.
    task automatic do_frame(input logic [3:0] new_kn, input bit glitch);
        int gstart, glen, chg;
        logic [3:0] gmask;
        gstart = $urandom_range(20, 60);
        glen   = $urandom_range(1, 10);
        chg    = $urandom_range(80, 150);
        gmask  = 4'($urandom_range(1, 15));
        @(posedge clk); #1;
        vsync_in = 1'b0;
        if (mon_en) model_tick(~k_n, cyc + 3);
        for (int i = 1; i < FRAME; i++) begin
            @(posedge clk); #1;
            if (i == VS_LEN) vsync_in = 1'b1;
            if (glitch && i == gstart) k_n = k_n ^ gmask;
            if (glitch && i == gstart + glen) k_n = k_n ^ gmask;
            if (i == chg) k_n = new_kn;
        end
    endtask

    // Monitor: pops on frame_tick, compares outputs on the following cycle,
    // and expects quiet outputs on every other cycle.
    initial begin
        logic [3:0] mv, dg, held_moves;
        logic [1:0] held_sel;
        bit         pend;
        exp_t       cur;
        held_moves = 4'h0;
        held_sel   = 2'd0;
        pend       = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mv = {moveF, moveL, moveR, moveB};
                dg = {debugD, debugC, debugB, debugA};
                if (pend) begin
                    pend = 1'b0;
                    check("moves", mv, cur.moves);
                    check("debug", dg, cur.dbg);
                    check("write_new_position", write_new_position, cur.wnp);
                    check("preset_sel", preset_sel, cur.sel);
                    held_moves = cur.moves;
                    held_sel   = cur.wnp ? 2'((int'(cur.sel) + 1) % NPRE) : cur.sel;
                end else begin
                    check("quiet", {write_new_position, preset_sel, dg, mv},
                          {1'b0, held_sel, 4'h0, held_moves});
                end
                if (frame_tick) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_tick: got unexpected tick expected none (cycle %0d)", cyc);
                    end else begin
                        cur = sb_q.pop_front();
                        check("tick_cycle", cyc, cur.tick_cyc);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [3:0] nk;
        logic [3:0] dir_tab [6];
        dir_tab = '{4'b1011, 4'b1111, 4'b1001, 4'b0001, 4'b0001, 4'b1111};

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {frame_tick, moveL, moveR, moveF, moveB, debugA, debugB, debugC, debugD,
               write_new_position, preset_sel}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int f = 0; f < 3; f++) do_frame(4'hF, 1'b0);
        for (int f = 0; f < 6; f++) do_frame(dir_tab[f], 1'b1);
        for (int f = 0; f < 5; f++) do_frame(4'h0, f == 0);
        do_frame(4'hF, 1'b0);

        for (int f = 0; f < 120; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 4) begin
                nk = k_n;
            end else begin
                case (r)
                    0, 1, 2: nk = 4'h0;
                    3:       nk = 4'hF;
                    4:       nk = 4'b1001;
                    5:       nk = 4'b0001;
                    6:       nk = 4'b0110;
                    default: nk = 4'($urandom_range(0, 15));
                endcase
            end
            do_frame(nk, $urandom_range(0, 1) == 1);
        end
        for (int f = 0; f < 4; f++) do_frame(4'hF, 1'b0);
        check("scoreboard_drained", sb_q.size(), 0);
        mon_en = 1'b0;

        // Reset asserted while the load strobe is high.
        found = 1'b0;
        k_n = 4'h0;
        for (int i = 0; i < 5 * FRAME && !found; i++) begin
            @(posedge clk); #1;
            vsync_in = ((i % FRAME) < VS_LEN) ? 1'b0 : 1'b1;
            if (write_new_position) begin
                reset_n = 1'b0;
                #1;
                check("reset_on_load_wnp", write_new_position, 1'b0);
                check("reset_on_load_sel", preset_sel, 2'd0);
                found = 1'b1;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL load_wait: got no strobe expected strobe within %0d cycles", 5 * FRAME);
        end
        vsync_in = 1'b1;
        k_n = 4'hF;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_state", {write_new_position, preset_sel}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/raybox_input_sched.md
Name: raybox_input_sched

Overview:
Sits between the board's raw pushbuttons and the raybox core. It synchronises and debounces the four K buttons, then decodes movement, debug and preset-load modes. Movement and debug commands are registered once per frame, on the vsync leading edge, so the core sees inputs that are stable for a whole frame. A small FSM sequences a one-cycle `write_new_position` strobe with a preset index when all four buttons are held for two frames.

Parameters:
- DB_BITS, 18, debounce counter width; input must differ from stable state for 2^DB_BITS-1 consecutive cycles (about 10.5 ms at 25 MHz).
- NUM_PRESETS, 4, number of preset positions; `preset_sel` wraps modulo this (must be ≤4).
- VSYNC_ACTIVE_LOW, 1, polarity of `vsync_in`.

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset_n  in  1  asynchronous, active-low reset
- k_n  in  4  raw buttons, active-low; bit3=K4 (top) .. bit0=K1 (bottom)
- vsync_in  in  1  vsync from raybox
- frame_tick  out  1  one-cycle pulse at vsync leading edge
- moveL, moveR, moveF, moveB  out  1 each  frame-held movement commands
- debugA, debugB, debugC, debugD  out  1 each  one-cycle debug pulses
- write_new_position  out  1  one-cycle preset load strobe
- preset_sel  out  2  preset index; valid while `write_new_position`=1

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset: all outputs 0; `preset_sel`=0; FSM=IDLE; debounced stable state=4'b1111 (released); synchronisers=1; debounce counters=0; vsync history=inactive.
- Synchronisation: each `k_n` bit and `vsync_in` pass through 2 flops.
- Debounce (per bit):
  - Counter clears whenever synced input equals stable.
  - Otherwise it increments; on reaching all-ones, stable takes the synced value and the counter clears.
  - Latency from a clean edge: 2 + (2^DB_BITS-1) cycles.
  - `pressed[i]` = !stable[i].
- frame_tick: registered, asserted the cycle after synced vsync goes from inactive to active.
- Decode on `pressed` (value registered before any same-cycle debounce update):
  - all4 = &pressed.
  - dbg1 = pressed[1]&pressed[2]&!all4.
  - dbg2 = pressed[0]&pressed[3]&!all4.
- Moves (updated only on frame_tick, held otherwise):
  - moveL=pressed[2], moveR=pressed[1], moveF=pressed[3], moveB=pressed[0].
  - All forced 0 if dbg1, dbg2, all4, or FSM≠IDLE.
- Debug (evaluated at frame_tick only):
  - Raw levels: A=dbg1&pressed[3], B=dbg1&pressed[0], C=dbg2&pressed[1], D=dbg2&pressed[2].
  - Output pulses for one cycle (the frame_tick cycle +1) only when the level is 1 now and was 0 at the previous frame_tick.
- Preset FSM (transitions only on frame_tick, except LOAD):
  - IDLE: all4 → ARMED.
  - ARMED: all4 → LOAD; else → IDLE.
  - LOAD (exactly one cycle): `write_new_position`=1 with current `preset_sel`; next cycle `preset_sel`←(preset_sel+1) mod NUM_PRESETS; → HOLD.
  - HOLD: at frame_tick with !(|pressed) → IDLE. Partial release stays in HOLD.
- Boundaries:
  - Holding all four indefinitely produces exactly one load.
  - Release during ARMED aborts with no strobe.
  - A vsync edge shorter than the 2-flop latency is still a single tick.
  - Reset mid-LOAD clears the strobe immediately; no increment.
  - `preset_sel` wraps from NUM_PRESETS-1 to 0.

Decomposition:
- Package raybox_input_pkg: FSM state enum (IDLE, ARMED, LOAD, HOLD), button index constants (K1..K4 → 0..3), default DB_BITS.
- Sub-module raybox_debounce: 2-flop synchroniser plus counter; one bit per instance; parameter DB_BITS; ports clk, reset_n, in_n, stable_n. Instantiate ×4.

Test Plan (simulate with DB_BITS=4, i.e. 15-cycle debounce; vsync period 200 cycles):
- Reset release, buttons idle → all outputs 0 and `preset_sel`=0 across 3 frames; frame_tick is one cycle wide, once per frame.
- k_n[2]=0 with 10-cycle glitches first, then held clean → no move from the glitches; moveL=1 from the first frame_tick after 17 stable cycles; moveL returns to 0 at the first frame_tick after release debounces.
- k_n=4'b1001 (K3+K2 held), then K4 also pressed → moves all 0; debugA pulses exactly once for 1 cycle; held for 3 more frames → no further pulses.
- k_n=4'b0000 held for 5 frames → exactly one `write_new_position` with `preset_sel`=0, 1 frame after ARMED; `preset_sel`=1 afterward; release then repeat 4 times → sequence 0,1,2,3,0.
- All-four held for 1 frame then released → ARMED→IDLE, no strobe; `reset_n` asserted on the LOAD cycle → strobe drops asynchronously, `preset_sel` stays 0.
